// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter that lets NUM_REQ producers share one
// FIFO write port. A winner owns the port for up to burst_len words (0 means
// 1). It holds the port through fifo_full back-pressure and gives it up early
// when it drops its request. Each release is followed by one IDLE arbitration
// cycle before the next grant.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [2:0]                    burst_len,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic [7:0]                    stall_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;
  logic [2:0]         beat_q, beat_d;
  logic [2:0]         burst_q, burst_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]         stall_q, stall_d;

  logic               owner_req;
  logic               wr_en;
  logic               owner_stall;
  logic               last_beat;
  logic               grant_done;
  logic [2:0]         burst_eff;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 cand;

  // Qualifiers for the current owner. A write is blocked while rst is high so
  // that a reset landing mid-burst never produces a stray write.
  assign owner_req   = req[owner_q];
  assign wr_en       = (state_q == GRANT) && owner_req && !fifo_full && !rst;
  assign owner_stall = (state_q == GRANT) && owner_req && fifo_full;
  assign last_beat   = ({1'b0, beat_q} + 4'd1) == {1'b0, burst_q};
  assign grant_done  = !owner_req || (wr_en && last_beat);
  assign burst_eff   = (burst_len == 3'd0) ? 3'd1 : burst_len;

  // Round-robin search: first requester strictly after the last winner, wrapping.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(last_winner_q) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE arbitrates, GRANT runs until the burst ends or req drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found)  state_d = GRANT;
      GRANT:   if (grant_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the owner, grant, beat counter, sampled burst and stall count.
  always_comb begin
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    beat_d        = beat_q;
    burst_d       = burst_q;
    gnt_d         = gnt_q;
    stall_d       = stall_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d          = win_idx;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          beat_d           = 3'd0;
          burst_d          = burst_eff;
        end
      end
      GRANT: begin
        if (wr_en) beat_d = beat_q + 3'd1;
        if (owner_stall && (stall_q != 8'hFF)) stall_d = stall_q + 8'd1;
        if (grant_done) begin
          gnt_d         = '0;
          last_winner_d = owner_q;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  // Datapath registers. Reset gives producer 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q       <= '0;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
      beat_q        <= 3'd0;
      burst_q       <= 3'd1;
      gnt_q         <= '0;
      stall_q       <= 8'd0;
    end else begin
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      beat_q        <= beat_d;
      burst_q       <= burst_d;
      gnt_q         <= gnt_d;
      stall_q       <= stall_d;
    end
  end

  // Outputs: the write strobe, ack and data follow the owner combinationally.
  always_comb begin
    fifo_wr      = wr_en;
    ack          = '0;
    if (wr_en) ack[owner_q] = 1'b1;
    fifo_wr_data = '0;
    if (state_q == GRANT)
      fifo_wr_data = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    gnt          = gnt_q;
    stall_cnt    = stall_q;
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: round-robin order, single requester,
// back-pressure, early release, mid-burst reset and stall saturation.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [2:0]       burst_len;
  logic             fifo_full;
  logic             fifo_wr;
  logic [DW-1:0]    fifo_wr_data;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    ack;
  logic [7:0]       stall_cnt;

  int pass_cnt  = 0;
  int check_cnt = 0;

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .burst_len    (burst_len),
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_wr_data (fifo_wr_data),
    .gnt          (gnt),
    .ack          (ack),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word_of(input int p);
    return DW'(8'hA0 + p);
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '0; burst_len = 3'd2; fifo_full = 1'b0;
    step();
    #1;
    check_cnt++;
    if (fifo_wr !== 1'b0 || ack !== 4'b0000) $display("FAIL rst_wr: got wr=%b ack=%b expected wr=0 ack=0000", fifo_wr, ack);
    else pass_cnt++;
    rst = 1'b0;
    step();
    #1;
    check_cnt++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt);
    else pass_cnt++;
    check_cnt++;
    if (stall_cnt !== 8'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
    else pass_cnt++;
    check_cnt++;
    if (fifo_wr !== 1'b0 || fifo_wr_data !== 8'h00) $display("FAIL reset_wr: got wr=%b data=%h expected wr=0 data=00", fifo_wr, fifo_wr_data);
    else pass_cnt++;
  endtask

  // All four request, burst 2: order 0,1,2,3,0 with one idle cycle between grants.
  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    req = 4'b1111; burst_len = 3'd2; fifo_full = 1'b0;
    for (int n = 0; n < 5; n++) begin
      for (int b = 0; b < 2; b++) begin
        step();
        #1;
        check_cnt++;
        if (gnt !== 4'(1 << order[n])) $display("FAIL rr_gnt: grant %0d beat %0d got %b expected %b", n, b, gnt, 4'(1 << order[n]));
        else pass_cnt++;
        check_cnt++;
        if (fifo_wr !== 1'b1 || fifo_wr_data !== word_of(order[n]) || ack !== 4'(1 << order[n]))
          $display("FAIL rr_write: grant %0d beat %0d got wr=%b data=%h ack=%b expected wr=1 data=%h ack=%b",
                   n, b, fifo_wr, fifo_wr_data, ack, word_of(order[n]), 4'(1 << order[n]));
        else pass_cnt++;
      end
      step();
      #1;
      check_cnt++;
      if (gnt !== 4'b0000 || fifo_wr !== 1'b0) $display("FAIL rr_idle: after grant %0d got gnt=%b wr=%b expected gnt=0000 wr=0", n, gnt, fifo_wr);
      else pass_cnt++;
    end
    req = 4'b0000;
    step();
  endtask

  // Only producer 2, burst_len 0 acts as 1: grant and idle alternate.
  task automatic test_single();
    req = 4'b0100; burst_len = 3'd0;
    for (int n = 0; n < 3; n++) begin
      step();
      #1;
      check_cnt++;
      if (gnt !== 4'b0100 || fifo_wr !== 1'b1 || fifo_wr_data !== word_of(2))
        $display("FAIL single_grant: round %0d got gnt=%b wr=%b data=%h expected gnt=0100 wr=1 data=%h", n, gnt, fifo_wr, fifo_wr_data, word_of(2));
      else pass_cnt++;
      step();
      #1;
      check_cnt++;
      if (gnt !== 4'b0000 || fifo_wr !== 1'b0) $display("FAIL single_idle: round %0d got gnt=%b wr=%b expected gnt=0000 wr=0", n, gnt, fifo_wr);
      else pass_cnt++;
    end
    req = 4'b0000;
    step();
  endtask

  // Producer 1, burst 4, three full cycles after word 2; burst_len changed mid-grant.
  task automatic test_stall();
    logic full_seq [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int   writes = 0;
    req = 4'b0010; burst_len = 3'd4; fifo_full = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step();
      fifo_full = full_seq[c];
      if (c == 1) burst_len = 3'd1;
      #1;
      if (fifo_wr === 1'b1) writes++;
      check_cnt++;
      if (gnt !== 4'b0010 || fifo_wr !== !full_seq[c])
        $display("FAIL stall_cycle: cycle %0d got gnt=%b wr=%b expected gnt=0010 wr=%b", c, gnt, fifo_wr, !full_seq[c]);
      else pass_cnt++;
      if (c == 5) begin
        check_cnt++;
        if (stall_cnt !== 8'd3) $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
        else pass_cnt++;
      end
    end
    step();
    #1;
    check_cnt++;
    if (writes != 4) $display("FAIL stall_words: got %0d expected 4", writes);
    else pass_cnt++;
    check_cnt++;
    if (gnt !== 4'b0000) $display("FAIL stall_release: got %b expected 0000", gnt);
    else pass_cnt++;
    req = 4'b0000; burst_len = 3'd4;
    step();
  endtask

  // Owner 2 drops after one word; next grant goes to 3. Then owner drops while full.
  task automatic test_drop();
    req = 4'b1111; burst_len = 3'd4; fifo_full = 1'b0;
    step();
    #1;
    check_cnt++;
    if (gnt !== 4'b0100 || fifo_wr !== 1'b1) $display("FAIL drop_first: got gnt=%b wr=%b expected gnt=0100 wr=1", gnt, fifo_wr);
    else pass_cnt++;
    step();
    req = 4'b1011;
    #1;
    check_cnt++;
    if (fifo_wr !== 1'b0) $display("FAIL drop_nowr: got %b expected 0", fifo_wr);
    else pass_cnt++;
    step();
    #1;
    check_cnt++;
    if (gnt !== 4'b0000) $display("FAIL drop_idle: got %b expected 0000", gnt);
    else pass_cnt++;
    step();
    req = 4'b0000;
    #1;
    check_cnt++;
    if (gnt !== 4'b1000) $display("FAIL drop_next: got %b expected 1000", gnt);
    else pass_cnt++;
    step();
    // last winner 3: producer 0 wins, then drops its request while the FIFO is full
    req = 4'b0001;
    step();
    req = 4'b0000; fifo_full = 1'b1;
    #1;
    check_cnt++;
    if (gnt !== 4'b0001 || fifo_wr !== 1'b0) $display("FAIL dropfull_cycle: got gnt=%b wr=%b expected gnt=0001 wr=0", gnt, fifo_wr);
    else pass_cnt++;
    step();
    #1;
    check_cnt++;
    if (gnt !== 4'b0000 || stall_cnt !== 8'd3) $display("FAIL dropfull_release: got gnt=%b stall=%0d expected gnt=0000 stall=3", gnt, stall_cnt);
    else pass_cnt++;
    fifo_full = 1'b0;
  endtask

  // Reset in the middle of producer 1's burst clears everything; producer 0 next.
  task automatic test_reset_mid();
    req = 4'b0010; burst_len = 3'd4;
    step();
    #1;
    check_cnt++;
    if (gnt !== 4'b0010 || fifo_wr !== 1'b1) $display("FAIL mid_grant: got gnt=%b wr=%b expected gnt=0010 wr=1", gnt, fifo_wr);
    else pass_cnt++;
    step();
    rst = 1'b1;
    #1;
    check_cnt++;
    if (fifo_wr !== 1'b0 || ack !== 4'b0000) $display("FAIL mid_rst_wr: got wr=%b ack=%b expected wr=0 ack=0000", fifo_wr, ack);
    else pass_cnt++;
    step();
    rst = 1'b0; req = 4'b1111;
    #1;
    check_cnt++;
    if (gnt !== 4'b0000 || stall_cnt !== 8'd0) $display("FAIL mid_after_rst: got gnt=%b stall=%0d expected gnt=0000 stall=0", gnt, stall_cnt);
    else pass_cnt++;
    step();
    req = 4'b0000;
    #1;
    check_cnt++;
    if (gnt !== 4'b0001) $display("FAIL mid_first_grant: got %b expected 0001", gnt);
    else pass_cnt++;
    step();
  endtask

  // Producer 0 held off by a full FIFO for 300 cycles: stall_cnt saturates.
  task automatic test_saturate();
    int wr_seen = 0;
    req = 4'b0001; burst_len = 3'd1; fifo_full = 1'b1;
    step();
    for (int c = 0; c < 300; c++) begin
      #1;
      if (fifo_wr !== 1'b0) wr_seen++;
      step();
    end
    #1;
    check_cnt++;
    if (wr_seen != 0) $display("FAIL sat_nowr: got %0d writes expected 0", wr_seen);
    else pass_cnt++;
    check_cnt++;
    if (stall_cnt !== 8'd255) $display("FAIL sat_cnt: got %0d expected 255", stall_cnt);
    else pass_cnt++;
    check_cnt++;
    if (gnt !== 4'b0001) $display("FAIL sat_hold: got %b expected 0001", gnt);
    else pass_cnt++;
    fifo_full = 1'b0;
    #1;
    check_cnt++;
    if (fifo_wr !== 1'b1 || fifo_wr_data !== word_of(0)) $display("FAIL sat_drain: got wr=%b data=%h expected wr=1 data=%h", fifo_wr, fifo_wr_data, word_of(0));
    else pass_cnt++;
    req = 4'b0000;
    step();
  endtask

  initial begin
    req_data = {word_of(3), word_of(2), word_of(1), word_of(0)};
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_drop();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
